// File: rtl/nonce_scheduler_if.sv
// Signal bundle tying the phase-2 nonce scheduler to the top FSM, the core array and the memory port.
interface nonce_scheduler_if #(
    parameter int NUM_CORES = 4
);
    logic                    start;
    logic [15:0]             output_addr;
    logic                    busy;
    logic                    done;
    logic [NUM_CORES-1:0]    core_start;
    logic [32*NUM_CORES-1:0] core_nonce;
    logic [NUM_CORES-1:0]    core_done;
    logic [32*NUM_CORES-1:0] core_h0;
    logic                    mem_we;
    logic [15:0]             mem_addr;
    logic [31:0]             mem_write_data;

    modport master (
        input  start, output_addr, core_done, core_h0,
        output busy, done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );

    modport slave (
        output start, output_addr, core_done, core_h0,
        input  busy, done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Phase-2 scheduler: hands nonces to a pool of SHA-256 cores and writes each core's H0
// to output_addr + nonce, one dispatch and one write per cycle at most.
module nonce_scheduler #(
    parameter int NUM_NONCES = 16,
    parameter int NUM_CORES  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    nonce_scheduler_if.master bus
);
    localparam int CW = $clog2(NUM_NONCES + 1);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    typedef enum logic [1:0] {FREE, RUNNING, PENDING} slot_t;

    state_t               state, next_state;
    slot_t                slot       [NUM_CORES];
    logic [CW-1:0]        slot_nonce [NUM_CORES];
    logic [31:0]          hold_h0    [NUM_CORES];
    logic [CW-1:0]        nonce_cnt;
    logic [PW-1:0]        rr_ptr;
    logic [15:0]          base_addr;

    logic                 disp_valid;
    logic [PW-1:0]        disp_idx;
    logic                 wb_valid;
    logic [PW-1:0]        wb_idx;
    logic                 all_free;
    logic [NUM_CORES-1:0] cap;
    logic                 busy_d, done_d;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        disp_valid = 1'b0;
        disp_idx   = '0;
        all_free   = 1'b1;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (slot[i] == FREE) begin
                disp_valid = 1'b1;
                disp_idx   = PW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
        disp_valid = disp_valid && (state == RUN) && (nonce_cnt < CW'(NUM_NONCES));
    end

    // Round-robin search begins one past the slot written last.
    always_comb begin
        wb_valid = 1'b0;
        wb_idx   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!wb_valid && slot[(int'(rr_ptr) + k) % NUM_CORES] == PENDING) begin
                wb_valid = 1'b1;
                wb_idx   = PW'((int'(rr_ptr) + k) % NUM_CORES);
            end
        end
        wb_valid = wb_valid && (state == RUN);
    end

    always_comb begin
        cap = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cap[i] = bus.core_done[i] && (slot[i] == RUNNING);
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= next_state;
            bus.busy <= busy_d;
            bus.done <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (nonce_cnt == CW'(NUM_NONCES) && all_free) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (next_state == RUN);
        done_d = (next_state == FINISH);
    end

    // Slot transitions FREE->RUNNING, RUNNING->PENDING, PENDING->FREE are mutually exclusive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nonce_cnt          <= '0;
            rr_ptr             <= '0;
            base_addr          <= '0;
            bus.core_start     <= '0;
            bus.core_nonce     <= '0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot[i]       <= FREE;
                slot_nonce[i] <= '0;
            end
        end else begin
            bus.core_start <= '0;
            bus.mem_we     <= 1'b0;

            if (state == IDLE && bus.start) begin
                base_addr <= bus.output_addr;
                nonce_cnt <= '0;
            end

            if (disp_valid) begin
                bus.core_start[disp_idx]            <= 1'b1;
                bus.core_nonce[32*disp_idx +: 32]   <= 32'(nonce_cnt);
                slot_nonce[disp_idx]                <= nonce_cnt;
                slot[disp_idx]                      <= RUNNING;
                nonce_cnt                           <= nonce_cnt + 1'b1;
            end

            for (int i = 0; i < NUM_CORES; i++) begin
                if (cap[i]) slot[i] <= PENDING;
            end

            // slot_nonce stays stable until redispatch, so it doubles as the captured nonce.
            if (wb_valid) begin
                bus.mem_we         <= 1'b1;
                bus.mem_addr       <= base_addr + 16'(slot_nonce[wb_idx]);
                bus.mem_write_data <= hold_h0[wb_idx];
                slot[wb_idx]       <= FREE;
                rr_ptr             <= wb_idx;
            end
        end
    end

    // NOTE: the H0 holding registers carry no reset; slot state alone says when they are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cap[i]) hold_h0[i] <= bus.core_h0[32*i +: 32];
        end
    end
endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: behavioural cores with programmable latency and a sparse memory model.
module tb_nonce_scheduler;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nonce_scheduler_if #(.NUM_CORES(NC)) bus16 ();
    nonce_scheduler_if #(.NUM_CORES(NC)) bus5 ();

    nonce_scheduler #(.NUM_NONCES(16), .NUM_CORES(NC)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
    nonce_scheduler #(.NUM_NONCES(5),  .NUM_CORES(NC)) dut5  (.clk(clk), .reset_n(reset_n), .bus(bus5));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int                lat   [2][NC];
    int                cnt   [2][NC] = '{default: 0};
    logic [31:0]       mnonce[2][NC] = '{default: '0};
    logic [NC-1:0]     mdone [2]     = '{default: '0};
    logic [32*NC-1:0]  mh0   [2]     = '{default: '0};
    logic [NC-1:0]     spur = '0;
    logic [NC-1:0]     cs;
    logic [32*NC-1:0]  cn;

    assign bus16.core_done = mdone[0] | spur;
    assign bus16.core_h0   = mh0[0];
    assign bus5.core_done  = mdone[1];
    assign bus5.core_h0    = mh0[1];

    logic [31:0] mem16 [logic [15:0]];
    logic [31:0] mem5  [logic [15:0]];
    int wq_addr16[$], wq_cyc16[$], wq_addr5[$], wq_cyc5[$];
    int dq_core16[$], dq_nonce16[$], dq_core5[$], dq_nonce5[$];
    int done_cnt[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};

    // Memory, completion and dispatch monitor plus behavioural core model, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            mem16.delete(); mem5.delete();
            wq_addr16.delete(); wq_cyc16.delete(); wq_addr5.delete(); wq_cyc5.delete();
            dq_core16.delete(); dq_nonce16.delete(); dq_core5.delete(); dq_nonce5.delete();
            done_cnt = '{0, 0};
            for (int d = 0; d < 2; d++) begin
                mdone[d] = '0;
                for (int i = 0; i < NC; i++) cnt[d][i] = 0;
            end
        end else begin
            if (bus16.mem_we) begin
                mem16[bus16.mem_addr] = bus16.mem_write_data;
                wq_addr16.push_back(int'(bus16.mem_addr));
                wq_cyc16.push_back(cyc);
            end
            if (bus5.mem_we) begin
                mem5[bus5.mem_addr] = bus5.mem_write_data;
                wq_addr5.push_back(int'(bus5.mem_addr));
                wq_cyc5.push_back(cyc);
            end
            if (bus16.done) begin done_cnt[0]++; done_cyc[0] = cyc; end
            if (bus5.done)  begin done_cnt[1]++; done_cyc[1] = cyc; end
            for (int d = 0; d < 2; d++) begin
                cs = (d == 0) ? bus16.core_start : bus5.core_start;
                cn = (d == 0) ? bus16.core_nonce : bus5.core_nonce;
                for (int i = 0; i < NC; i++) begin
                    mdone[d][i] = 1'b0;
                    if (cs[i]) begin
                        cnt[d][i]    = lat[d][i];
                        mnonce[d][i] = cn[32*i +: 32];
                        if (d == 0) begin dq_core16.push_back(i); dq_nonce16.push_back(int'(cn[32*i +: 32])); end
                        else        begin dq_core5.push_back(i);  dq_nonce5.push_back(int'(cn[32*i +: 32]));  end
                    end else if (cnt[d][i] > 0) begin
                        cnt[d][i]--;
                        if (cnt[d][i] == 0) begin
                            mdone[d][i]          = 1'b1;
                            mh0[d][32*i +: 32]   = 32'hA000_0000 + mnonce[d][i];
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        spur = '0;
        bus16.start = 1'b0;
        bus5.start  = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic start_run(input int d, input logic [15:0] addr);
        @(negedge clk); #1;
        if (d == 0) begin bus16.output_addr = addr; bus16.start = 1'b1; end
        else        begin bus5.output_addr  = addr; bus5.start  = 1'b1; end
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus5.start  = 1'b0;
    endtask

    task automatic wait_done(input int d, input int max_cyc);
        int n = 0;
        while (done_cnt[d] == 0 && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("done_seen_d%0d", d), 32'(done_cnt[d] != 0), 32'd1);
    endtask

    task automatic check_image16(input string tag);
        for (int n = 0; n < 16; n++) begin
            logic [15:0] a;
            a = 16'h0100 + 16'(n);
            check($sformatf("%s_mem%0d", tag, n), mem16.exists(a) ? mem16[a] : 32'hDEAD_BEEF,
                  32'hA000_0000 + 32'(n));
        end
        check({tag, "_wcnt"}, 32'(wq_addr16.size()), 32'd16);
        check({tag, "_done_once"}, 32'(done_cnt[0]), 32'd1);
        check({tag, "_busy_after"}, 32'(bus16.busy), 32'd0);
    endtask

    function automatic void set_lat(input int d, input int l0, input int l1, input int l2, input int l3);
        lat[d][0] = l0; lat[d][1] = l1; lat[d][2] = l2; lat[d][3] = l3;
    endfunction

    initial begin
        bus16.start = 1'b0; bus16.output_addr = '0;
        bus5.start  = 1'b0; bus5.output_addr  = '0;
        set_lat(0, 10, 10, 10, 10);
        set_lat(1, 10, 10, 10, 10);

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",   32'(bus16.busy), 32'd0);
        check("rst_done",   32'(bus16.done), 32'd0);
        check("rst_we",     32'(bus16.mem_we), 32'd0);
        check("rst_addr",   32'(bus16.mem_addr), 32'd0);
        check("rst_wdata",  bus16.mem_write_data, 32'd0);
        check("rst_cstart", 32'(bus16.core_start), 32'd0);
        check("rst_cnonce", 32'(|bus16.core_nonce), 32'd0);
        reset_n = 1'b1;
        @(negedge clk); #1;

        // Test 1: uniform latency 10, first-dispatch timing
        @(negedge clk); #1;
        bus16.output_addr = 16'h0100;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        check("t1_busy_c0",   32'(bus16.busy), 32'd1);
        check("t1_cstart_c0", 32'(bus16.core_start), 32'd0);
        @(posedge clk); #1;
        check("t1_cstart_c1", 32'(bus16.core_start), 32'h1);
        check("t1_cnonce0",   bus16.core_nonce[31:0], 32'd0);
        wait_done(0, 400);
        check("t1_busy_at_done", 32'(bus16.busy), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check_image16("t1");

        // Test 2: latencies 13,5,9,7
        set_lat(0, 13, 5, 9, 7);
        do_reset();
        start_run(0, 16'h0100);
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        check("t2_first_addr", 32'(wq_addr16[0]), 32'h0101);
        check("t2_first_data", mem16.exists(16'h0101) ? mem16[16'h0101] : 32'hDEAD_BEEF, 32'hA000_0001);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_disp_core%0d", k),  32'(dq_core16[k]),  32'(k));
            check($sformatf("t2_disp_nonce%0d", k), 32'(dq_nonce16[k]), 32'(k));
        end
        check_image16("t2");

        // Test 3: all four cores finish together with pointer at 0
        set_lat(0, 13, 12, 11, 10);
        do_reset();
        start_run(0, 16'h0100);
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        check("t3_w0_addr", 32'(wq_addr16[0]), 32'h0101);
        check("t3_w1_addr", 32'(wq_addr16[1]), 32'h0102);
        check("t3_w2_addr", 32'(wq_addr16[2]), 32'h0103);
        check("t3_w3_addr", 32'(wq_addr16[3]), 32'h0100);
        for (int k = 1; k < 4; k++)
            check($sformatf("t3_consec%0d", k), 32'(wq_cyc16[k] - wq_cyc16[k-1]), 32'd1);
        check_image16("t3");

        // Test 4: 5 nonces on 4 cores, base address wrapping past 0xFFFF
        set_lat(1, 10, 10, 10, 10);
        do_reset();
        start_run(1, 16'hFFFE);
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        #1;
        check("t4_ndisp",     32'(dq_core5.size()), 32'd5);
        check("t4_disp4core", 32'(dq_core5[4]),  32'd0);
        check("t4_disp4nonce",32'(dq_nonce5[4]), 32'd4);
        check("t4_wcnt",      32'(wq_addr5.size()), 32'd5);
        for (int n = 0; n < 5; n++) begin
            logic [15:0] a;
            a = 16'hFFFE + 16'(n);
            check($sformatf("t4_mem%0d", n), mem5.exists(a) ? mem5[a] : 32'hDEAD_BEEF, 32'hA000_0000 + 32'(n));
        end
        check("t4_done_once",  32'(done_cnt[1]), 32'd1);
        check("t4_done_after", 32'(done_cyc[1] - wq_cyc5[4]), 32'd1);
        check("t4_busy_after", 32'(bus5.busy), 32'd0);

        // Test 5: spurious core_done on FREE cores and a second start during RUN
        set_lat(0, 10, 10, 10, 10);
        do_reset();
        start_run(0, 16'h0100);
        @(posedge clk); #1;
        spur = 4'b1110;
        @(posedge clk); #1;
        spur = '0;
        bus16.output_addr = 16'h0200;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        check_image16("t5");

        // Test 6: reset after three writes, then a clean rerun
        do_reset();
        start_run(0, 16'h0100);
        begin
            int n = 0;
            while (wq_addr16.size() < 3 && n < 300) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check("t6_three_writes", 32'(wq_addr16.size()), 32'd3);
        reset_n = 1'b0;
        #1;
        check("t6_busy",   32'(bus16.busy), 32'd0);
        check("t6_done",   32'(bus16.done), 32'd0);
        check("t6_we",     32'(bus16.mem_we), 32'd0);
        check("t6_addr",   32'(bus16.mem_addr), 32'd0);
        check("t6_wdata",  bus16.mem_write_data, 32'd0);
        check("t6_cstart", 32'(bus16.core_start), 32'd0);
        check("t6_cnonce", 32'(|bus16.core_nonce), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        start_run(0, 16'h0100);
        wait_done(0, 400);
        repeat (3) @(negedge clk);
        #1;
        check_image16("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequences the phase-2 SHA-256 cores of the bitcoin hasher.
- Hands nonce values 0..NUM_NONCES-1 to a pool of NUM_CORES twophase_sha256 instances, collects each core's final H0 word, and writes it to output memory at output_addr + nonce through the shared memory port.
- Sits between the top-level FSM (after phase 1 completes) and the phase-2 core array.

Parameters:
- NUM_NONCES, 16, total nonces to hash (1..256).
- NUM_CORES, 4, phase-2 core instances managed (1..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- output_addr  in  16  base word address for results; sampled at start.
- core_start  out  NUM_CORES  per-core one-cycle start pulse.
- core_nonce  out  32*NUM_CORES  per-core nonce; slice i = bits 32i+31:32i.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_h0  in  32*NUM_CORES  per-core H0 result; valid in the core_done cycle only.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory word address.
- mem_write_data  out  32  memory write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all results are written.

Behaviour:
- Reset: all outputs 0, state IDLE, all cores FREE, nonce counter 0, round-robin pointer 0.
- All outputs are registered.
- Top states: IDLE, RUN, FINISH.
  - IDLE: start=1 latches output_addr, clears nonce counter, goes to RUN, sets busy.
  - RUN: dispatch and writeback proceed concurrently. Go to FINISH when nonce counter = NUM_NONCES and every core is FREE.
  - FINISH: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored outside IDLE.
- Per-core slot states: FREE, RUNNING, PENDING.
- Dispatch:
  - At most one dispatch per cycle, to the lowest-index FREE core, while nonce counter < NUM_NONCES.
  - core_start[i] pulses in the following cycle; core_nonce[i] is updated in that same cycle and held until core i's next dispatch.
  - The slot becomes RUNNING and the counter increments.
  - First dispatch: core_start[0] is high in the second cycle after the start sample edge.
- Capture:
  - core_done[i] with slot i RUNNING stores core_h0[i] and the slot's nonce into the slot's hold registers; the slot becomes PENDING.
  - Any number of cores may finish in the same cycle; all are captured.
  - core_done[i] while the slot is not RUNNING is ignored.
- Writeback:
  - At most one write per cycle, to a PENDING slot chosen round-robin starting at pointer+1.
  - Next cycle: mem_we=1, mem_addr = output_addr + nonce (16-bit wrap), mem_write_data = held H0.
  - The slot becomes FREE and the pointer moves to that slot. mem_we is 0 otherwise.
- A slot freed by a write is eligible for dispatch in the following cycle, not the same cycle.
- Results are written in completion order, not nonce order. Addressing by nonce makes the final memory image order-independent.
- core_start and core_done for the same core in the same cycle cannot occur, because the slot is FREE when started.
- Reset asserted mid-run: immediate return to reset state. Partially written results are left as-is. Cores are reset separately by the top level.
- NUM_NONCES < NUM_CORES: only cores 0..NUM_NONCES-1 are used.

Test Plan:
- NUM_NONCES=16, NUM_CORES=4, each core_done 10 cycles after core_start, core_h0 = 0xA000_0000 + nonce, output_addr=0x0100 -> 16 writes; mem[0x0100+n] = 0xA000_0000+n for n=0..15; done pulses once; busy low afterwards.
- Core latencies 13, 5, 9, 7 cycles for cores 0..3 -> first write is nonce 1 at 0x0101. Dispatch order is nonces 0,1,2,3 to cores 0,1,2,3. Final memory image matches the first test.
- All 4 cores finish in the same cycle with the pointer at 0 -> writes on 4 consecutive cycles in slot order 1,2,3,0; no results lost.
- NUM_NONCES=5, NUM_CORES=4 -> core 0 gets nonces 0 and 4; exactly 5 writes; done follows the fifth write once all cores are FREE.
- start pulsed again during RUN; spurious core_done on a FREE core -> both ignored; write count and values unchanged.
- reset_n low after 3 writes -> all outputs 0 immediately, state IDLE. A fresh start then completes all 16 writes correctly.
